// File: rtl/serial_sub_8b_if.sv
// Request/response val/rdy bundle for the bit-serial subtractor.
// The requester side (master) drives operands and accepts results; the subtractor side is the slave.
interface serial_sub_8b_if #(
   parameter int NBITS = 8
);
   logic             req_val;
   logic             req_rdy;
   logic [NBITS-1:0] req_in0;
   logic [NBITS-1:0] req_in1;
   logic             resp_val;
   logic             resp_rdy;
   logic [NBITS-1:0] resp_out;
   logic             resp_borrow;

   modport master (
      output req_val,
      output req_in0,
      output req_in1,
      output resp_rdy,
      input  req_rdy,
      input  resp_val,
      input  resp_out,
      input  resp_borrow
   );

   modport slave (
      input  req_val,
      input  req_in0,
      input  req_in1,
      input  resp_rdy,
      output req_rdy,
      output resp_val,
      output resp_out,
      output resp_borrow
   );
endinterface

// File: rtl/serial_sub_8b.sv
// Bit-serial two's-complement subtractor: in0 - in1, one bit per cycle LSB first,
// behind val/rdy request and response handshakes. Result and borrow-out are registered.
module serial_sub_8b #(
   parameter int NBITS = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   serial_sub_8b_if.slave bus
);

   localparam int CW = $clog2(NBITS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_req_rdy;
   logic             w_resp_val;

   logic [NBITS-1:0] r_a;
   logic [NBITS-1:0] r_b;
   logic [NBITS-1:0] r_res;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic [NBITS-1:0] r_out;
   logic             r_out_borrow;

   logic             w_accept;
   logic             w_calc;
   logic             w_last;
   logic             w_diff;
   logic             w_borrow_nxt;
   logic [NBITS-1:0] w_res_shift;

   // Full-subtractor borrow: a - b - bin underflows.
   function automatic logic f_borrow(input logic a, input logic b, input logic bin);
      return (~a & b) | (~a & bin) | (b & bin);
   endfunction

   assign w_accept     = (r_state == ST_IDLE) & bus.req_val;
   assign w_calc       = (r_state == ST_CALC);
   assign w_last       = w_calc & (r_cnt == CW'(NBITS - 1));
   assign w_diff       = r_a[0] ^ r_b[0] ^ r_borrow;
   assign w_borrow_nxt = f_borrow(r_a[0], r_b[0], r_borrow);
   assign w_res_shift  = {w_diff, r_res[NBITS-1:1]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs depend on state alone; unused encodings fall back to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_req_rdy   = 1'b0;
      w_resp_val  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_rdy = 1'b1;
            if (bus.req_val) begin
               w_state_nxt = ST_CALC;
            end
         end
         ST_CALC: begin
            if (r_cnt == CW'(NBITS - 1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_resp_val = 1'b1;
            if (bus.resp_rdy) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_a      <= bus.req_in0;
         r_b      <= bus.req_in1;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
      end else if (w_calc) begin
         r_a      <= {1'b0, r_a[NBITS-1:1]};
         r_b      <= {1'b0, r_b[NBITS-1:1]};
         r_res    <= w_res_shift;
         r_borrow <= w_borrow_nxt;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   // Separate output registers so the visible result survives the next operation's shifting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out        <= '0;
         r_out_borrow <= 1'b0;
      end else if (w_last) begin
         r_out        <= w_res_shift;
         r_out_borrow <= w_borrow_nxt;
      end
   end

   assign bus.req_rdy     = w_req_rdy;
   assign bus.resp_val    = w_resp_val;
   assign bus.resp_out    = r_out;
   assign bus.resp_borrow = r_out_borrow;

endmodule
